// File: rtl/traffic_phase_sequencer.sv
// Two-road intersection phase sequencer with pedestrian walk service.
// Optional flashing-yellow override is built in with `define TRAFFIC_FLASH_EN.
module traffic_phase_sequencer #(
    parameter int CNT_W    = 8,
    parameter int TICK_DIV = 50000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [CNT_W-1:0] green_time,
    input  logic [CNT_W-1:0] yellow_time,
    input  logic [CNT_W-1:0] allred_time,
    input  logic [CNT_W-1:0] walk_time,
    input  logic             ped_req,
`ifdef TRAFFIC_FLASH_EN
    input  logic             flash,
`endif
    output logic             ped_ack,
    output logic             walk,
    output logic [1:0]       light_a,
    output logic [1:0]       light_b,
    output logic             advance,
    output logic [2:0]       phase
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

    localparam logic [1:0] L_OFF = 2'b00;
    localparam logic [1:0] L_RED = 2'b01;
    localparam logic [1:0] L_GRN = 2'b10;
    localparam logic [1:0] L_YEL = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_A_GRN = 3'd1,
        S_A_YEL = 3'd2,
        S_RED1  = 3'd3,
        S_B_GRN = 3'd4,
        S_B_YEL = 3'd5,
        S_RED2  = 3'd6,
        S_WALK  = 3'd7
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [PW-1:0]    r_presc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ped;
    logic             r_flash;
    logic             r_blink;

    logic             w_flash_in;
    logic             w_flash_start;
    logic             w_blink_nxt;
    logic             w_run;
    logic             w_tick;
    logic             w_entry;
    logic             w_presc_clr;
    logic [CNT_W-1:0] w_dur;
    logic [CNT_W-1:0] w_load;
    logic [1:0]       w_la;
    logic [1:0]       w_lb;

`ifdef TRAFFIC_FLASH_EN
    assign w_flash_in = flash;
`else
    assign w_flash_in = 1'b0;
`endif

    // Flash mode parks the FSM in IDLE but keeps the prescaler running.
    assign w_run         = (r_state != S_IDLE) || r_flash;
    assign w_tick        = w_run && (r_presc == PMAX);
    assign w_flash_start = w_flash_in && !r_flash;
    assign w_presc_clr   = w_entry || w_flash_start ||
                           ((w_next == S_IDLE) && !w_flash_in);

    always_comb begin
        w_next  = r_state;
        w_entry = 1'b0;
        if (w_flash_in) begin
            w_next = S_IDLE;
        end else if (r_flash) begin
            if (enable) begin
                w_next  = S_RED1;
                w_entry = 1'b1;
            end else begin
                w_next = S_IDLE;
            end
        end else if (!enable) begin
            w_next = S_IDLE;
        end else if (r_state == S_IDLE) begin
            w_next  = S_A_GRN;
            w_entry = 1'b1;
        end else if (w_tick && (r_cnt == '0)) begin
            w_entry = 1'b1;
            unique case (r_state)
                S_A_GRN: w_next = S_A_YEL;
                S_A_YEL: w_next = S_RED1;
                S_RED1:  w_next = S_B_GRN;
                S_B_GRN: w_next = S_B_YEL;
                S_B_YEL: w_next = S_RED2;
                S_RED2:  w_next = r_ped ? S_WALK : S_A_GRN;
                S_WALK:  w_next = S_A_GRN;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_dur = '0;
        unique case (w_next)
            S_A_GRN, S_B_GRN: w_dur = green_time;
            S_A_YEL, S_B_YEL: w_dur = yellow_time;
            S_RED1, S_RED2:   w_dur = allred_time;
            S_WALK:           w_dur = walk_time;
            default:          w_dur = '0;
        endcase
        // A zero duration still runs one full tick.
        w_load = (w_dur == '0) ? '0 : w_dur - CNT_W'(1);
    end

    always_comb begin
        w_blink_nxt = r_blink;
        if (w_flash_start) begin
            w_blink_nxt = 1'b1;
        end else if (r_flash && w_tick) begin
            w_blink_nxt = ~r_blink;
        end
    end

    always_comb begin
        w_la = L_OFF;
        w_lb = L_OFF;
        if (w_flash_in) begin
            w_la = w_blink_nxt ? L_YEL : L_OFF;
            w_lb = w_blink_nxt ? L_YEL : L_OFF;
        end else begin
            unique case (w_next)
                S_A_GRN: begin w_la = L_GRN; w_lb = L_RED; end
                S_A_YEL: begin w_la = L_YEL; w_lb = L_RED; end
                S_B_GRN: begin w_la = L_RED; w_lb = L_GRN; end
                S_B_YEL: begin w_la = L_RED; w_lb = L_YEL; end
                S_RED1, S_RED2, S_WALK: begin
                    w_la = L_RED;
                    w_lb = L_RED;
                end
                default: begin w_la = L_OFF; w_lb = L_OFF; end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_presc <= '0;
            r_cnt   <= '0;
            r_ped   <= 1'b0;
            r_flash <= 1'b0;
            r_blink <= 1'b0;
            ped_ack <= 1'b0;
            walk    <= 1'b0;
            light_a <= L_OFF;
            light_b <= L_OFF;
            advance <= 1'b0;
            phase   <= 3'd0;
        end else begin
            r_state <= w_next;
            r_flash <= w_flash_in;
            r_blink <= w_blink_nxt;

            if (w_presc_clr || w_tick) begin
                r_presc <= '0;
            end else begin
                r_presc <= r_presc + PW'(1);
            end

            if (w_entry) begin
                r_cnt <= w_load;
            end else if (w_next == S_IDLE) begin
                r_cnt <= '0;
            end else if (w_tick && (r_cnt != '0)) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end

            // Walk entry wins over a same-cycle request.
            if (w_entry && (w_next == S_WALK)) begin
                r_ped <= 1'b0;
            end else if (ped_req && (r_state != S_WALK)) begin
                r_ped <= 1'b1;
            end

            ped_ack <= w_entry && (w_next == S_WALK);
            walk    <= (w_next == S_WALK);
            light_a <= w_la;
            light_b <= w_lb;
            advance <= w_entry;
            phase   <= w_next;
        end
    end

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Directed bench for traffic_phase_sequencer with TICK_DIV=4.
module tb_traffic_phase_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [7:0] green_time;
    logic [7:0] yellow_time;
    logic [7:0] allred_time;
    logic [7:0] walk_time;
    logic       ped_req;
    logic       ped_ack;
    logic       walk;
    logic [1:0] light_a;
    logic [1:0] light_b;
    logic       advance;
    logic [2:0] phase;
`ifdef TRAFFIC_FLASH_EN
    logic       flash = 1'b0;
`endif

    int tests = 0;
    int fails = 0;

    traffic_phase_sequencer #(
        .CNT_W(8),
        .TICK_DIV(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .green_time(green_time),
        .yellow_time(yellow_time),
        .allred_time(allred_time),
        .walk_time(walk_time),
        .ped_req(ped_req),
`ifdef TRAFFIC_FLASH_EN
        .flash(flash),
`endif
        .ped_ack(ped_ack),
        .walk(walk),
        .light_a(light_a),
        .light_b(light_b),
        .advance(advance),
        .phase(phase)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] ph;
        logic [1:0] la;
        logic [1:0] lb;
        logic       wk;
        logic       ack;
        int         dur;
        logic       ped;
        int         newg;
    } rec_t;

    rec_t tbl[41];

    function automatic rec_t mk(input logic [2:0] ph, input logic [1:0] la,
                                input logic [1:0] lb, input logic wk,
                                input logic ack, input int dur,
                                input logic ped, input int newg);
        rec_t r;
        r.ph = ph; r.la = la; r.lb = lb; r.wk = wk; r.ack = ack;
        r.dur = dur; r.ped = ped; r.newg = newg;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Entered on the first cycle of a phase; returns on the first cycle of the next.
    task automatic run_phase(input int idx);
        rec_t r;
        int   n;
        bit   bad;
        r = tbl[idx];
        chk($sformatf("r%0d_phase", idx), 32'(phase), 32'(r.ph));
        chk($sformatf("r%0d_lamp_a", idx), 32'(light_a), 32'(r.la));
        chk($sformatf("r%0d_lamp_b", idx), 32'(light_b), 32'(r.lb));
        chk($sformatf("r%0d_walk", idx), 32'(walk), 32'(r.wk));
        chk($sformatf("r%0d_ack", idx), 32'(ped_ack), 32'(r.ack));
        chk($sformatf("r%0d_advance", idx), 32'(advance), 32'd1);
        if (r.ped) ped_req = 1'b1;
        n = 1;
        bad = 1'b0;
        while (n < 400) begin
            @(negedge clk);
            ped_req = 1'b0;
            if (r.newg != 0 && n == 3) green_time = 8'(r.newg);
            if (phase != r.ph) break;
            n++;
            if (advance || ped_ack || walk != r.wk ||
                light_a != r.la || light_b != r.lb) bad = 1'b1;
        end
        chk($sformatf("r%0d_cycles", idx), 32'(n), 32'(r.dur));
        chk($sformatf("r%0d_steady", idx), 32'(bad), 32'd0);
    endtask

    task automatic run_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) run_phase(i);
    endtask

    initial begin
        tbl[0]  = mk(3'd1, 2'b10, 2'b01, 0, 0, 12, 0, 0);
        tbl[1]  = mk(3'd2, 2'b11, 2'b01, 0, 0,  8, 0, 0);
        tbl[2]  = mk(3'd3, 2'b01, 2'b01, 0, 0,  4, 0, 0);
        tbl[3]  = mk(3'd4, 2'b01, 2'b10, 0, 0, 12, 0, 0);
        tbl[4]  = mk(3'd5, 2'b01, 2'b11, 0, 0,  8, 0, 0);
        tbl[5]  = mk(3'd6, 2'b01, 2'b01, 0, 0,  4, 0, 0);
        tbl[6]  = mk(3'd1, 2'b10, 2'b01, 0, 0, 12, 0, 0);
        tbl[7]  = mk(3'd2, 2'b11, 2'b01, 0, 0,  8, 0, 0);
        tbl[8]  = mk(3'd3, 2'b01, 2'b01, 0, 0,  4, 0, 0);
        tbl[9]  = mk(3'd4, 2'b01, 2'b10, 0, 0, 12, 1, 0);
        tbl[10] = mk(3'd5, 2'b01, 2'b11, 0, 0,  8, 0, 0);
        tbl[11] = mk(3'd6, 2'b01, 2'b01, 0, 0,  4, 0, 0);
        tbl[12] = mk(3'd7, 2'b01, 2'b01, 1, 1,  8, 0, 0);
        tbl[13] = mk(3'd1, 2'b10, 2'b01, 0, 0, 12, 0, 0);
        tbl[14] = mk(3'd2, 2'b11, 2'b01, 0, 0,  8, 0, 0);
        tbl[15] = mk(3'd3, 2'b01, 2'b01, 0, 0,  4, 0, 0);
        tbl[16] = mk(3'd4, 2'b01, 2'b10, 0, 0, 12, 0, 0);
        tbl[17] = mk(3'd5, 2'b01, 2'b11, 0, 0,  8, 0, 0);
        tbl[18] = mk(3'd6, 2'b01, 2'b01, 0, 0,  4, 0, 0);
        tbl[19] = mk(3'd1, 2'b10, 2'b01, 0, 0,  4, 0, 0);
        tbl[20] = mk(3'd2, 2'b11, 2'b01, 0, 0,  8, 0, 3);
        tbl[21] = mk(3'd3, 2'b01, 2'b01, 0, 0,  4, 0, 0);
        tbl[22] = mk(3'd4, 2'b01, 2'b10, 0, 0, 12, 0, 0);
        tbl[23] = mk(3'd5, 2'b01, 2'b11, 0, 0,  8, 0, 0);
        tbl[24] = mk(3'd6, 2'b01, 2'b01, 0, 0,  4, 0, 0);
        tbl[25] = mk(3'd1, 2'b10, 2'b01, 0, 0, 12, 0, 5);
        tbl[26] = mk(3'd2, 2'b11, 2'b01, 0, 0,  8, 0, 0);
        tbl[27] = mk(3'd3, 2'b01, 2'b01, 0, 0,  4, 0, 0);
        tbl[28] = mk(3'd4, 2'b01, 2'b10, 0, 0, 20, 0, 0);
        tbl[29] = mk(3'd5, 2'b01, 2'b11, 0, 0,  8, 0, 0);
        tbl[30] = mk(3'd6, 2'b01, 2'b01, 0, 0,  4, 0, 0);
        tbl[31] = mk(3'd1, 2'b10, 2'b01, 0, 0, 20, 0, 0);
        tbl[32] = mk(3'd1, 2'b10, 2'b01, 0, 0, 20, 0, 0);
        tbl[33] = mk(3'd2, 2'b11, 2'b01, 0, 0,  8, 0, 0);
        tbl[34] = mk(3'd3, 2'b01, 2'b01, 0, 0,  4, 0, 0);
        tbl[35] = mk(3'd1, 2'b10, 2'b01, 0, 0, 20, 0, 0);
        tbl[36] = mk(3'd2, 2'b11, 2'b01, 0, 0,  8, 0, 0);
        tbl[37] = mk(3'd3, 2'b01, 2'b01, 0, 0,  4, 0, 0);
        tbl[38] = mk(3'd4, 2'b01, 2'b10, 0, 0, 20, 0, 0);
        tbl[39] = mk(3'd5, 2'b01, 2'b11, 0, 0,  8, 0, 0);
        tbl[40] = mk(3'd6, 2'b01, 2'b01, 0, 0,  4, 0, 0);

        rst = 1'b1;
        enable = 1'b0;
        green_time = 8'd3;
        yellow_time = 8'd2;
        allred_time = 8'd1;
        walk_time = 8'd2;
        ped_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_phase", 32'(phase), 32'd0);
        chk("reset_lamp_a", 32'(light_a), 32'd0);
        chk("reset_lamp_b", 32'(light_b), 32'd0);
        chk("reset_walk", 32'(walk), 32'd0);
        chk("reset_ack", 32'(ped_ack), 32'd0);
        chk("reset_advance", 32'(advance), 32'd0);

        rst = 1'b0;
        enable = 1'b1;
        @(negedge clk);
        run_range(0, 18);
        chk("no_rewalk_phase", 32'(phase), 32'd1);
        chk("no_rewalk_adv", 32'(advance), 32'd1);

        enable = 1'b0;
        @(negedge clk);
        chk("off_phase", 32'(phase), 32'd0);
        green_time = 8'd0;
        enable = 1'b1;
        @(negedge clk);
        run_range(19, 31);

        chk("drop_in_yel", 32'(phase), 32'd2);
        repeat (3) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        chk("drop_phase", 32'(phase), 32'd0);
        chk("drop_lamp_a", 32'(light_a), 32'd0);
        chk("drop_lamp_b", 32'(light_b), 32'd0);
        chk("drop_advance", 32'(advance), 32'd0);
        enable = 1'b1;
        @(negedge clk);
        chk("reen_phase", 32'(phase), 32'd1);
        chk("reen_advance", 32'(advance), 32'd1);
        chk("reen_lamp_a", 32'(light_a), 32'd2);
        run_range(32, 34);

        chk("rst_in_bgrn", 32'(phase), 32'd4);
        ped_req = 1'b1;
        @(negedge clk);
        ped_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_phase", 32'(phase), 32'd0);
        chk("midrst_lamp_a", 32'(light_a), 32'd0);
        chk("midrst_lamp_b", 32'(light_b), 32'd0);
        chk("midrst_walk", 32'(walk), 32'd0);
        chk("midrst_advance", 32'(advance), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        run_range(35, 40);
        chk("rst_clr_ped_phase", 32'(phase), 32'd1);
        chk("rst_clr_ped_walk", 32'(walk), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/traffic_phase_sequencer.md
Name: traffic_phase_sequencer

Overview:
Two-road intersection controller. It sequences road A and road B lamps through green, yellow and all-red phases with run-time programmable durations. It serves latched pedestrian requests with a walk interval and emits a one-cycle advance strobe per phase change. It sits above the per-road lamp state logic and drives lamp codes 00=OFF, 01=RED, 10=GREEN, 11=YELLOW.

Parameters:
CNT_W, 8, width of duration inputs and the phase down-counter
TICK_DIV, 50000000, clk cycles per timing tick (1 s at 50 MHz); minimum 2

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
enable  input  1  1 = run sequence; 0 = return to IDLE
green_time  input  CNT_W  green duration in ticks
yellow_time  input  CNT_W  yellow duration in ticks
allred_time  input  CNT_W  all-red clearance in ticks
walk_time  input  CNT_W  pedestrian walk duration in ticks
ped_req  input  1  pedestrian button, level or pulse
ped_ack  output  1  one-cycle pulse when walk begins
walk  output  1  high during the WALK phase
light_a  output  2  road A lamp code
light_b  output  2  road B lamp code
advance  output  1  one-cycle pulse on every phase transition
phase  output  3  current state encoding, for debug

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, prescaler=0, counter=0, ped_pending=0. Outputs: light_a=light_b=00, walk=0, ped_ack=0, advance=0. Reset overrides everything, including mid-phase.
- States and encodings: IDLE=0, A_GRN=1, A_YEL=2, RED1=3, B_GRN=4, B_YEL=5, RED2=6, WALK=7.
- Lamps:
  - IDLE: A=00, B=00.
  - A_GRN: A=10, B=01.
  - A_YEL: A=11, B=01.
  - RED1, RED2, WALK: A=01, B=01.
  - B_GRN: A=01, B=10.
  - B_YEL: A=01, B=11.
  - All outputs are registered.
- Prescaler:
  - Counts 0..TICK_DIV-1 while state != IDLE. tick=1 in the cycle it equals TICK_DIV-1.
  - Cleared to 0 on every phase entry, so each phase starts a full tick period.
  - Held at 0 in IDLE.
- Phase counter:
  - On entry to a phase, load duration-1 from the relevant input. A duration of 0 is treated as 1.
  - Duration inputs are sampled only at entry; changes mid-phase take effect from the next phase.
  - Decrement on tick. When tick occurs with counter==0, transition at that clock edge.
  - A phase of N ticks therefore lasts exactly N*TICK_DIV cycles.
- Transitions:
  - IDLE -> A_GRN when enable=1; this takes effect 1 cycle after enable is sampled high.
  - A_GRN -> A_YEL -> RED1 -> B_GRN -> B_YEL -> RED2.
  - RED2 -> WALK if ped_pending=1, else RED2 -> A_GRN.
  - WALK -> A_GRN.
- advance: pulses for exactly one cycle in the first cycle of each new phase, including IDLE -> A_GRN. It does not pulse on an enable-forced return to IDLE.
- Pedestrian handshake:
  - ped_pending is set on any cycle with ped_req=1 and state != WALK.
  - On entering WALK: ped_ack pulses for 1 cycle, walk=1, and ped_pending clears.
  - ped_req during WALK is ignored; holding ped_req high across WALK re-arms ped_pending only after WALK exits.
  - Multiple requests in one cycle collapse into a single service.
- enable=0 in any non-IDLE state: next cycle state=IDLE, lamps 00, walk=0. ped_pending is retained.
- Simultaneous events: rst beats enable; enable=0 beats a tick-driven transition in the same cycle.

Optional Feature:
TRAFFIC_FLASH_EN
- Defined: adds input flash (1 bit). When flash=1 and rst=0, state is forced to IDLE-equivalent FLASH handling:
  - Both lamps alternate 11/00 every tick, starting with 11.
  - walk=0; ped_pending is held, not cleared.
  - The prescaler runs.
  - On flash falling, the sequence resumes at RED1 (all-red clearance) if enable=1, otherwise goes to IDLE.
- Undefined: no flash port; behaviour exactly as above.

Test Plan:
- TICK_DIV=4, green=3, yellow=2, allred=1, enable=1 after reset -> A_GRN lasts 12 cycles, A_YEL 8, RED1 4, B_GRN 12, B_YEL 8, RED2 4, back to A_GRN; advance pulses once at each of the 7 entries.
- ped_req 1-cycle pulse during B_GRN, walk=2 -> after RED2: WALK for 8 cycles, ped_ack=1 on its first cycle, walk=1 throughout, lamps 01/01; next phase is A_GRN and ped_pending=0.
- green_time=0 -> A_GRN lasts 4 cycles (treated as 1 tick); green_time changed from 3 to 5 mid-A_GRN -> current phase still 12 cycles, next B_GRN 20 cycles.
- enable dropped mid-A_YEL -> next cycle light_a=light_b=00, phase=0, no advance pulse; enable re-raised -> A_GRN 1 cycle later with advance=1.
- rst asserted mid-B_GRN with ped_pending=1 -> next cycle all outputs 0, ped_pending cleared, no WALK after restart.
- (TRAFFIC_FLASH_EN) flash=1 during B_GRN -> both lamps 11 for 4 cycles, 00 for 4 cycles, repeating; flash=0 -> RED1 entered with advance=1.
